// File: rtl/inv_round_key_sequencer.sv
// Inverse round-key sequencer: stores NR+1 AES round keys, then streams one
// decryption key pass, XOR-ing each accepted state beat with key[NR] down to key[0].
module inv_round_key_sequencer #(
  parameter  int unsigned NR = 10,
  localparam int unsigned DW = 128,
  localparam int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr_en,
  input  logic [DW-1:0] key_wr_data,
  output logic          load_done,
  input  logic          start,
  input  logic          istate_valid,
  output logic          istate_ready,
  input  logic [DW-1:0] istate,
  output logic          ostate_valid,
  input  logic          ostate_ready,
  output logic [DW-1:0] ostate,
  output logic          ostate_last,
  output logic [RW-1:0] rnd,
  output logic          busy
);

  localparam logic [RW-1:0] LAST_IDX = RW'(NR);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [DW-1:0] key_mem [NR+1];
  logic [RW-1:0] wr_ptr;

  logic          accept;
  logic          key_we;
  logic [RW-1:0] key_addr;
  logic          reload;
  logic          load_last;
  logic          start_pass;

  // Input side may only advance while running and the output slot is free or emptying.
  assign istate_ready = (state == S_RUN) && (!ostate_valid || ostate_ready);

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_next = state;
    accept     = istate_valid && istate_ready;
    key_we     = 1'b0;
    key_addr   = wr_ptr;
    reload     = 1'b0;
    load_last  = 1'b0;
    start_pass = 1'b0;
    case (state)
      S_LOAD: begin
        if (key_wr_en) begin
          key_we = 1'b1;
          if (wr_ptr == LAST_IDX) begin
            load_last  = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        // A key write restarts the load and wins over a same-cycle start.
        if (key_wr_en) begin
          key_we     = 1'b1;
          key_addr   = '0;
          reload     = 1'b1;
          state_next = S_LOAD;
        end else if (start) begin
          start_pass = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && (rnd == '0)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ostate_valid && ostate_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Key storage; contents survive reset but are treated as invalid until reloaded.
  always_ff @(posedge clk) begin
    if (!rst && key_we) begin
      key_mem[key_addr] <= key_wr_data;
    end
  end

  // Write pointer and load completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      load_done <= 1'b0;
    end else begin
      if (reload) begin
        wr_ptr <= RW'(1);
      end else if (key_we) begin
        wr_ptr <= wr_ptr + RW'(1);
      end
      if (reload) begin
        load_done <= 1'b0;
      end else if (load_last) begin
        load_done <= 1'b1;
      end
    end
  end

  // Round index: starts at NR, steps down per accepted beat, saturates at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd <= '0;
    end else if (start_pass) begin
      rnd <= LAST_IDX;
    end else if (accept && (rnd != '0)) begin
      rnd <= rnd - RW'(1);
    end
  end

  // Busy mirrors the RUN/DRAIN phase of the pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next == S_RUN) || (state_next == S_DRAIN);
    end
  end

  // Single-entry output register; refills on the same cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      ostate_valid <= 1'b0;
      ostate       <= '0;
      ostate_last  <= 1'b0;
    end else if (accept) begin
      ostate_valid <= 1'b1;
      ostate       <= istate ^ key_mem[rnd];
      ostate_last  <= (rnd == '0);
    end else if (ostate_ready) begin
      ostate_valid <= 1'b0;
    end
  end

  // A stalled output beat must hold its payload until it is taken.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (ostate_valid && !ostate_ready) |=> (ostate_valid && $stable(ostate) && $stable(ostate_last)));

endmodule

// File: tb/tb_inv_round_key_sequencer.sv
// Bench for inv_round_key_sequencer: FIPS-197 key load, vector table pass,
// scoreboarded passes with backpressure, reload and mid-pass reset.
module tb_inv_round_key_sequencer;

  localparam int unsigned NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_wr_en;
  logic [127:0] key_wr_data;
  logic         load_done;
  logic         start;
  logic         istate_valid;
  logic         istate_ready;
  logic [127:0] istate;
  logic         ostate_valid;
  logic         ostate_ready;
  logic [127:0] ostate;
  logic         ostate_last;
  logic [3:0]   rnd;
  logic         busy;

  inv_round_key_sequencer #(.NR(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_wr_en    (key_wr_en),
    .key_wr_data  (key_wr_data),
    .load_done    (load_done),
    .start        (start),
    .istate_valid (istate_valid),
    .istate_ready (istate_ready),
    .istate       (istate),
    .ostate_valid (ostate_valid),
    .ostate_ready (ostate_ready),
    .ostate       (ostate),
    .ostate_last  (ostate_last),
    .rnd          (rnd),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    logic         last;
  } vec_t;

  typedef struct {
    logic [127:0] dout;
    logic         last;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_beats = 0;
  int           m_idx   = int'(NR);
  logic [127:0] key_model [NR+1];
  exp_t         sb_q [$];
  vec_t         vt [NR+1];

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accepted input beat, pop on taken output beat.
  task automatic monitor();
    exp_t e;
    if (rst) begin
      sb_q.delete();
      m_idx = int'(NR);
      return;
    end
    if (ostate_valid && ostate_ready) begin
      n_beats++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: unexpected beat %h expected none", ostate);
      end else begin
        e = sb_q.pop_front();
        check("sb_ostate", ostate, e.dout);
        check("sb_last", 128'(ostate_last), 128'(e.last));
      end
    end
    if (istate_valid && istate_ready) begin
      check("sb_rnd", 128'(rnd), 128'(m_idx));
      e.dout = istate ^ key_model[m_idx];
      e.last = (m_idx == 0);
      sb_q.push_back(e);
      m_idx = (m_idx == 0) ? int'(NR) : m_idx - 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ostate_valid"}, 128'(ostate_valid), '0);
    check({tag, "_ostate"}, ostate, '0);
    check({tag, "_ostate_last"}, 128'(ostate_last), '0);
    check({tag, "_rnd"}, 128'(rnd), '0);
    check({tag, "_busy"}, 128'(busy), '0);
    check({tag, "_load_done"}, 128'(load_done), '0);
    check({tag, "_istate_ready"}, 128'(istate_ready), '0);
  endtask

  // One pass of random beats; optional key writes while running and a 3-cycle output stall.
  task automatic run_pass(input bit garbage, input bit stall);
    int           b0;
    logic [127:0] held;
    b0   = n_beats;
    held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pass_busy", 128'(busy), 128'(1));
    check("pass_rnd_start", 128'(rnd), 128'(NR));
    istate_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      istate       = rand128();
      ostate_ready = !(stall && c >= 4 && c < 7);
      key_wr_en    = garbage && (c < 11);
      key_wr_data  = rand128();
      #1;
      if (stall && c >= 4 && c < 7) begin
        if (c == 4) held = ostate;
        check("stall_istate_ready", 128'(istate_ready), '0);
        check("stall_ostate_valid", 128'(ostate_valid), 128'(1));
      end
      tick();
      if (stall && c >= 4 && c < 7) check("stall_hold", ostate, held);
    end
    istate_valid = 1'b0;
    key_wr_en    = 1'b0;
    ostate_ready = 1'b1;
    check("pass_idle", 128'(busy), '0);
    check("pass_beats", 128'(n_beats - b0), 128'(NR + 1));
    check("pass_sb_empty", 128'(sb_q.size()), '0);
  endtask

  initial begin
    key_model[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    key_model[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    key_model[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    key_model[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    key_model[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    key_model[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    key_model[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    key_model[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    key_model[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    key_model[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    key_model[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vt[0] = '{din: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              dout: 128'h7ad5fda789ef4e272bca100b3d9ff59f, last: 1'b0};
    for (int k = 1; k < int'(NR); k++) begin
      vt[k].din  = rand128();
      vt[k].dout = vt[k].din ^ key_model[int'(NR) - k];
      vt[k].last = 1'b0;
    end
    vt[NR] = '{din: 128'h00112233445566778899aabbccddeeff,
               dout: 128'h00102030405060708090a0b0c0d0e0f0, last: 1'b1};

    // Reset with all request inputs asserted.
    rst          = 1'b1;
    key_wr_en    = 1'b1;
    key_wr_data  = rand128();
    start        = 1'b1;
    istate_valid = 1'b1;
    istate       = rand128();
    ostate_ready = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    rst          = 1'b0;
    key_wr_en    = 1'b0;
    start        = 1'b0;
    istate_valid = 1'b0;
    ostate_ready = 1'b1;
    tick();
    check_reset("post_rst");

    // Key load with a gap and an ignored start.
    for (int i = 0; i <= int'(NR); i++) begin
      key_wr_en   = 1'b1;
      key_wr_data = key_model[i];
      start       = (i == 5);
      tick();
      check("load_done", 128'(load_done), 128'(i == int'(NR)));
      if (i == 5) check("start_in_load", 128'(busy), '0);
      if (i == 3) begin
        key_wr_en = 1'b0;
        start     = 1'b0;
        tick();
        check("load_gap", 128'(load_done), '0);
      end
    end
    key_wr_en = 1'b0;
    start     = 1'b0;
    check("idle_ready", 128'(istate_ready), '0);

    // Vector table pass at full throughput.
    start = 1'b1;
    tick();
    start = 1'b0;
    ostate_ready = 1'b1;
    istate_valid = 1'b1;
    for (int k = 0; k <= int'(NR); k++) begin
      istate = vt[k].din;
      #1;
      check("vec_istate_ready", 128'(istate_ready), 128'(1));
      tick();
      check("vec_ostate_valid", 128'(ostate_valid), 128'(1));
      check("vec_ostate", ostate, vt[k].dout);
      check("vec_ostate_last", 128'(ostate_last), 128'(vt[k].last));
      if (k == 0) check("vec_rnd_after_first", 128'(rnd), 128'(NR - 1));
    end
    istate_valid = 1'b0;
    check("drain_busy", 128'(busy), 128'(1));
    tick();
    check("done_busy", 128'(busy), '0);
    check("done_ostate_valid", 128'(ostate_valid), '0);

    // Output backpressure mid-pass.
    run_pass(1'b0, 1'b1);

    // Reload wins over start in the same IDLE cycle; new keys everywhere.
    for (int i = 0; i <= int'(NR); i++) key_model[i] = rand128();
    key_wr_en   = 1'b1;
    key_wr_data = key_model[0];
    start       = 1'b1;
    tick();
    key_wr_en = 1'b0;
    start     = 1'b0;
    check("reload_load_done", 128'(load_done), '0);
    check("reload_busy", 128'(busy), '0);
    tick();
    check("reload_no_pass", 128'(busy), '0);
    for (int i = 1; i <= int'(NR); i++) begin
      key_wr_en   = 1'b1;
      key_wr_data = key_model[i];
      tick();
    end
    key_wr_en = 1'b0;
    check("reload_done", 128'(load_done), 128'(1));

    // Key writes during RUN must not disturb stored keys.
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b1);

    // Reset after five beats of a pass.
    start = 1'b1;
    tick();
    start        = 1'b0;
    istate_valid = 1'b1;
    ostate_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      istate = rand128();
      tick();
    end
    rst       = 1'b1;
    start     = 1'b1;
    key_wr_en = 1'b1;
    tick();
    check_reset("midpass_rst");
    rst          = 1'b0;
    start        = 1'b0;
    key_wr_en    = 1'b0;
    istate_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("norel_busy", 128'(busy), '0);
    check("norel_load_done", 128'(load_done), '0);
    check("norel_istate_ready", 128'(istate_ready), '0);
    tick();
    check("norel_busy2", 128'(busy), '0);
    check("final_sb_empty", 128'(sb_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_round_key_sequencer.md
INV_ROUND_KEY_SEQUENCER -- requirements
Module: inv_round_key_sequencer

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning number of AES rounds (11 round keys, indices 0..NR).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port key_wr_en, input, 1, strobe writing one round key per cycle.
REQ-005 The block SHALL have port key_wr_data, input, 128, round key written in ascending order: round 0 first, round NR last.
REQ-006 The block SHALL have port load_done, output, 1, high when all NR+1 keys are stored.
REQ-007 The block SHALL have port start, input, 1, single-cycle request to begin one decryption key pass.
REQ-008 The block SHALL have port istate_valid / istate_ready, input / output, 1 each, input state handshake.
REQ-009 The block SHALL have port istate, input, 128, state to combine with the current round key.
REQ-010 The block SHALL have port ostate_valid / ostate_ready, output / input, 1 each, output handshake.
REQ-011 The block SHALL have port ostate, output, 128, registered istate XOR key[rnd].
REQ-012 The block SHALL have port ostate_last, output, 1, marks the beat produced with key index 0.
REQ-013 The block SHALL have port rnd, output, 4, round index applied to the next accepted beat.
REQ-014 The block SHALL have port busy, output, 1, high in RUN or DRAIN.

Function
REQ-015 The FSM SHALL have states LOAD, IDLE, RUN and DRAIN; reset state is LOAD.
REQ-016 In LOAD, each key_wr_en SHALL store key_wr_data at wr_ptr and increment wr_ptr; the write at wr_ptr==NR SHALL enter IDLE and set load_done on the next cycle.
REQ-017 In IDLE, key_wr_en SHALL clear load_done, store to index 0, set wr_ptr=1 and enter LOAD (reload); it SHALL take priority over a simultaneous start.
REQ-018 In IDLE, start SHALL set rnd=NR and enter RUN; start in any other state SHALL be ignored.
REQ-019 In RUN and DRAIN, key_wr_en SHALL be ignored and stored keys SHALL be unchanged.
REQ-020 istate_ready SHALL equal (state==RUN) and (not ostate_valid or ostate_ready); it SHALL be combinational with no dependency on istate_valid.
REQ-021 On accept (istate_valid and istate_ready), ostate SHALL load istate XOR key[rnd] and ostate_valid SHALL be set, with 1-cycle latency; ostate_last SHALL load (rnd==0).
REQ-022 On accept with rnd>0, rnd SHALL decrement by 1; on accept with rnd==0, the FSM SHALL enter DRAIN and rnd SHALL hold 0 (no wrap).
REQ-023 ostate_valid SHALL clear when ostate_ready is high and no new beat is accepted that cycle; a simultaneous accept and drain SHALL keep ostate_valid high with new data (full throughput: one beat per cycle).
REQ-024 ostate, ostate_last SHALL be stable while ostate_valid and not ostate_ready.
REQ-025 In DRAIN, the FSM SHALL return to IDLE on the cycle the last beat is taken (ostate_valid and ostate_ready).
REQ-026 A pass SHALL emit exactly NR+1 beats, in key order NR, NR-1, ..., 0.

Reset
REQ-027 Reset SHALL force state=LOAD, wr_ptr=0, load_done=0, rnd=0, ostate_valid=0, ostate_last=0, ostate=0, busy=0.
REQ-028 Reset asserted mid-pass or mid-load SHALL abort it; pending output SHALL be dropped; stored key contents need not be cleared but SHALL be treated as invalid until 11 new writes.
REQ-029 start, key_wr_en and istate_valid during reset SHALL have no effect.

Verification
REQ-030 Load the FIPS-197 AES-128 expansion of key 000102030405060708090a0b0c0d0e0f (11 writes) -> load_done=1 the cycle after the 11th write, and not before.
REQ-031 start, then beat istate=69c4e0d86a7b0430d8cdb78070b4c55a with ostate_ready=1 -> ostate=7ad5fda789ef4e272bca100b3d9ff59f one cycle later, rnd=9.
REQ-032 Full pass with continuous valid/ready -> 11 beats on 11 consecutive cycles; 11th beat istate=00112233445566778899aabbccddeeff gives ostate=00102030405060708090a0b0c0d0e0f0 with ostate_last=1, then IDLE.
REQ-033 ostate_ready held low for 3 cycles mid-pass -> istate_ready low, ostate constant, no beat lost or duplicated.
REQ-034 key_wr_en and start in the same IDLE cycle -> LOAD entered, load_done=0, no pass started; key_wr_en during RUN -> keys unchanged.
REQ-035 rst pulsed after 5 beats of a pass -> all outputs at reset values next cycle; start without reload is ignored (load_done=0).
